// File: rtl/clock_rst_gen.sv
// Purpose : divides the system clock into clk_out and holds rst_out asserted
//           for a programmable number of clk_out rising edges after start.
// Latency : outputs are registered and respond on the edge that samples start/stop/rst.
// Backpr. : none; start/stop are 1-cycle strobes that are always accepted.
//
// Ports:
//   clock, rst        system clock, synchronous active-high reset
//   start, stop       command strobes (start wins when both are high)
//   cfg_half          clk_out half-period in clock cycles (0 behaves as 1)
//   cfg_rst_cycles    clk_out rising edges with rst_out asserted
//   cfg_phase         clk_out level at start
//   clk_out, rst_out  generated clock and reset (reset level set by ACTIVE)
//   busy, locked      busy in RESET/RUN, locked in RUN
module clock_rst_gen #(
  parameter bit ACTIVE = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_rst_cycles,
  input  logic             cfg_phase,
  output logic             clk_out,
  output logic             rst_out,
  output logic             busy,
  output logic             locked
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0]   edge_cnt, edge_cnt_nxt;
  logic [CNT_W-1:0]   half_q, half_q_nxt;
  logic [CNT_W-1:0]   rcyc_q, rcyc_q_nxt;
  logic               phase_q, phase_q_nxt;
  logic               clk_out_nxt, rst_out_nxt, busy_nxt, locked_nxt;

  logic               toggle;
  logic [CNT_W-1:0]   edge_inc;

  // Divider terminal count; half_q is never 0 so half_q-1 cannot underflow.
  assign toggle   = (div_cnt == (half_q - CNT_W'(1)));
  // Saturating rising-edge count.
  assign edge_inc = (edge_cnt == {CNT_W{1'b1}}) ? edge_cnt : edge_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      half_q   <= CNT_W'(1);
      rcyc_q   <= '0;
      phase_q  <= 1'b0;
      clk_out  <= 1'b0;
      rst_out  <= ACTIVE;
      busy     <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      half_q   <= half_q_nxt;
      rcyc_q   <= rcyc_q_nxt;
      phase_q  <= phase_q_nxt;
      clk_out  <= clk_out_nxt;
      rst_out  <= rst_out_nxt;
      busy     <= busy_nxt;
      locked   <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    edge_cnt_nxt = edge_cnt;
    half_q_nxt   = half_q;
    rcyc_q_nxt   = rcyc_q;
    phase_q_nxt  = phase_q;
    clk_out_nxt  = clk_out;
    rst_out_nxt  = rst_out;
    busy_nxt     = busy;
    locked_nxt   = locked;

    if (start) begin
      // Full (re)start from any state.
      half_q_nxt   = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
      rcyc_q_nxt   = cfg_rst_cycles;
      phase_q_nxt  = cfg_phase;
      clk_out_nxt  = cfg_phase;
      div_cnt_nxt  = '0;
      edge_cnt_nxt = '0;
      busy_nxt     = 1'b1;
      if (cfg_rst_cycles == '0) begin
        state_nxt   = ST_RUN;
        rst_out_nxt = ~ACTIVE;
        locked_nxt  = 1'b1;
      end else begin
        state_nxt   = ST_RESET;
        rst_out_nxt = ACTIVE;
        locked_nxt  = 1'b0;
      end
    end else if (stop && state != ST_IDLE) begin
      state_nxt   = ST_IDLE;
      clk_out_nxt = phase_q;
      rst_out_nxt = ACTIVE;
      busy_nxt    = 1'b0;
      locked_nxt  = 1'b0;
    end else if (state != ST_IDLE) begin
      if (toggle) begin
        div_cnt_nxt = '0;
        clk_out_nxt = ~clk_out;
      end else begin
        div_cnt_nxt = div_cnt + CNT_W'(1);
      end
      // A 0->1 toggle is a rising edge; release reset on the Nth one.
      if (state == ST_RESET && toggle && !clk_out) begin
        edge_cnt_nxt = edge_inc;
        if (edge_inc == rcyc_q) begin
          state_nxt   = ST_RUN;
          rst_out_nxt = ~ACTIVE;
          locked_nxt  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_rst_gen.sv
module tb_clock_rst_gen;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             rst, start, stop, cfg_phase;
  logic [CNT_W-1:0] cfg_half, cfg_rst_cycles;
  logic             clk_out, rst_out, busy, locked;

  int n_chk  = 0;
  int n_fail = 0;

  clock_rst_gen #(.ACTIVE(1'b0), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .cfg_half       (cfg_half),
    .cfg_rst_cycles (cfg_rst_cycles),
    .cfg_phase      (cfg_phase),
    .clk_out        (clk_out),
    .rst_out        (rst_out),
    .busy           (busy),
    .locked         (locked)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic c, input logic r,
                           input logic b, input logic l);
    check({tag, ".clk_out"}, 32'(clk_out), 32'(c));
    check({tag, ".rst_out"}, 32'(rst_out), 32'(r));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".locked"},  32'(locked),  32'(l));
  endtask

  // Pulse start with the given config; returns after edge k has been sampled.
  task automatic do_start(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] n,
                          input logic p, input logic with_stop);
    cfg_half = h; cfg_rst_cycles = n; cfg_phase = p;
    start = 1'b1; stop = with_stop;
    step();
    start = 1'b0; stop = 1'b0;
    // Scramble cfg afterwards; it must be ignored until the next start.
    cfg_half = 16'd7; cfg_rst_cycles = 16'd1; cfg_phase = ~p;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_half = '0; cfg_rst_cycles = '0; cfg_phase = 1'b0;

    // Reset for 3 cycles, then idle with no toggling.
    repeat (3) step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // half=3, N=10, phase=0: toggles every 3 cycles, reset released at k+57.
    do_start(16'd3, 16'd10, 1'b0, 1'b0);
    check_all("p0.k", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 62; i++) begin
      step();
      check("p0.clk_out", 32'(clk_out), 32'((i / 3) % 2));
      check("p0.rst_out", 32'(rst_out), 32'(i >= 57));
      check("p0.locked",  32'(locked),  32'(i >= 57));
    end

    // Restart from RUN with phase=1: clk_out=1 at k, first fall at k+3, release at k+60.
    do_start(16'd3, 16'd10, 1'b1, 1'b0);
    check_all("p1.k", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 63; i++) begin
      step();
      check("p1.clk_out", 32'(clk_out), 32'(((i / 3) % 2) == 0));
      check("p1.rst_out", 32'(rst_out), 32'(i >= 60));
    end

    // half=0, N=0: behaves as half=1, locked from edge k.
    do_start(16'd0, 16'd0, 1'b0, 1'b0);
    check_all("h0.k", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check_all("h0.run", 1'(i % 2), 1'b1, 1'b1, 1'b1);
    end

    // Start together with stop while locked: restart wins; half=2, N=2 releases at k+6.
    do_start(16'd2, 16'd2, 1'b0, 1'b1);
    check_all("rs.k", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("rs.clk_out", 32'(clk_out), 32'((i / 2) % 2));
      check("rs.rst_out", 32'(rst_out), 32'(i >= 6));
      check("rs.locked",  32'(locked),  32'(i >= 6));
    end

    // Stop in RUN with latched phase=1, half=2: clk_out returns to 1 and freezes.
    do_start(16'd2, 16'd0, 1'b1, 1'b0);
    step(); step();             // i=2: first toggle, clk_out now 0
    check("st.pre", 32'(clk_out), 32'(0));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_all("st.k", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("st.hold", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // Stop while idle has no effect.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_all("st.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // rst in the middle of RESET returns everything to reset values.
    do_start(16'd3, 16'd10, 1'b1, 1'b0);
    repeat (10) step();
    check("mr.busy", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    check_all("mr.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    // rst wins over a simultaneous start.
    start = 1'b1; cfg_half = 16'd1; cfg_rst_cycles = 16'd0; cfg_phase = 1'b1;
    step();
    check_all("mr.win", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; rst = 1'b0;
    step();
    check_all("mr.after", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
